// File: rtl/segment_display_if.sv
// Purpose : bundles the code/override inputs and segment outputs of one seven-segment digit.
// Latency : n/a (signal bundle only).
// Backpressure: none; the digit accepts a new code every cycle.
// Ports   : bcd[3:0], blank, lamp_test (to decoder); seg[6:0], invalid (from decoder).
interface segment_display_if;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg;
  logic       invalid;

  // master drives the code and overrides, slave (the decoder) drives the pins
  modport master (output bcd, output blank, output lamp_test,
                  input  seg, input  invalid);
  modport slave  (input  bcd, input  blank, input  lamp_test,
                  output seg, output invalid);
endinterface

// File: rtl/segment_display.sv
// Purpose : registered 4-bit code to 7-segment decoder with blank and lamp-test overrides.
// Latency : 1 clock from sampled code to seg/invalid.
// Backpressure: none; a new code is accepted every cycle.
// Ports   : clk, rst_n (async active-low); bus.slave: bcd, blank, lamp_test in; seg, invalid out.
module segment_display #(
  parameter bit HEX_EN       = 1'b1,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  segment_display_if.slave   bus
);

  // Reset drives every segment dark in whichever polarity the pins use.
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;

  logic [6:0] w_pat;          // logical pattern, lit = 1, bit0 = segment a
  logic       w_invalid_next;
  logic [6:0] w_seg_next;
  logic [6:0] r_seg;
  logic       r_invalid;

  always_comb begin
    w_pat          = 7'h00;
    w_invalid_next = 1'b0;
    if (bus.lamp_test) begin
      w_pat = 7'h7F;
    end else if (bus.blank) begin
      w_pat = 7'h00;
    end else begin
      case (bus.bcd)
        4'd0:    w_pat = 7'h3F;
        4'd1:    w_pat = 7'h06;
        4'd2:    w_pat = 7'h5B;
        4'd3:    w_pat = 7'h4F;
        4'd4:    w_pat = 7'h66;
        4'd5:    w_pat = 7'h6D;
        4'd6:    w_pat = 7'h7D;
        4'd7:    w_pat = 7'h07;
        4'd8:    w_pat = 7'h7F;
        4'd9:    w_pat = 7'h6F;
        default: begin
          // Codes 10-15: hex glyphs, or a dark digit flagged invalid.
          if (HEX_EN) begin
            case (bus.bcd)
              4'd10:   w_pat = 7'h77; // A
              4'd11:   w_pat = 7'h7C; // b
              4'd12:   w_pat = 7'h39; // C
              4'd13:   w_pat = 7'h5E; // d
              4'd14:   w_pat = 7'h79; // E
              default: w_pat = 7'h71; // F
            endcase
          end else begin
            w_pat          = 7'h00;
            w_invalid_next = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_seg_next = COMMON_ANODE ? ~w_pat : w_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg     <= SEG_OFF;
      r_invalid <= 1'b0;
    end else begin
      r_seg     <= w_seg_next;
      r_invalid <= w_invalid_next;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.invalid = r_invalid;

endmodule

// File: tb/tb_segment_display.sv
// Purpose : directed check of three decoder variants (hex, no-hex, common-anode) on shared stimulus.
// Latency : expects seg/invalid one clock after the sampled code.
// Backpressure: none exercised; stimulus changes every cycle.
module tb_segment_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;

  int total = 0;
  int bad   = 0;

  // Hand-written segment table, lit = 1, bit0 = a.
  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  segment_display_if if_hex ();
  segment_display_if if_nohex ();
  segment_display_if if_ca ();

  assign if_hex.bcd         = bcd;
  assign if_hex.blank       = blank;
  assign if_hex.lamp_test   = lamp_test;
  assign if_nohex.bcd       = bcd;
  assign if_nohex.blank     = blank;
  assign if_nohex.lamp_test = lamp_test;
  assign if_ca.bcd          = bcd;
  assign if_ca.blank        = blank;
  assign if_ca.lamp_test    = lamp_test;

  segment_display #(.HEX_EN(1'b1), .COMMON_ANODE(1'b0)) u_hex   (.clk(clk), .rst_n(rst_n), .bus(if_hex));
  segment_display #(.HEX_EN(1'b0), .COMMON_ANODE(1'b0)) u_nohex (.clk(clk), .rst_n(rst_n), .bus(if_nohex));
  segment_display #(.HEX_EN(1'b1), .COMMON_ANODE(1'b1)) u_ca    (.clk(clk), .rst_n(rst_n), .bus(if_ca));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, look 1 ns later.
  task automatic step(input logic [3:0] b, input logic bl, input logic lt);
    @(negedge clk);
    bcd       = b;
    blank     = bl;
    lamp_test = lt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] exp_prev;
    logic [6:0] exp_now;
    logic [3:0] v;

    // Reset held with clock running and a live code on the input.
    rst_n = 1'b0; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hex_seg",   if_hex.seg,           7'h00);
    chk("rst_hex_inv",   {6'd0, if_hex.invalid}, 7'h00);
    chk("rst_nohex_seg", if_nohex.seg,         7'h00);
    chk("rst_nohex_inv", {6'd0, if_nohex.invalid}, 7'h00);
    chk("rst_ca_seg",    if_ca.seg,            7'h7F);

    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep 0..15, then back to 0 so the no-hex invalid flag falls.
    for (int i = 0; i <= 16; i++) begin
      v = 4'(i % 16);
      step(v, 1'b0, 1'b0);
      chk($sformatf("sweep_hex_seg_%0d", i), if_hex.seg, PAT[v]);
      chk($sformatf("sweep_hex_inv_%0d", i), {6'd0, if_hex.invalid}, 7'h00);
      chk($sformatf("sweep_nohex_seg_%0d", i), if_nohex.seg, (v < 4'd10) ? PAT[v] : 7'h00);
      chk($sformatf("sweep_nohex_inv_%0d", i), {6'd0, if_nohex.invalid}, {6'd0, (v >= 4'd10)});
      chk($sformatf("sweep_ca_seg_%0d", i), if_ca.seg, 7'h7F ^ PAT[v]);
    end

    // Override priority.
    step(4'd3, 1'b1, 1'b0);
    chk("blank_hex",   if_hex.seg, 7'h00);
    chk("blank_nohex", if_nohex.seg, 7'h00);
    chk("blank_ca",    if_ca.seg, 7'h7F);
    step(4'd3, 1'b1, 1'b1);
    chk("lamp_over_blank_hex", if_hex.seg, 7'h7F);
    chk("lamp_over_blank_ca",  if_ca.seg, 7'h00);
    step(4'd12, 1'b0, 1'b1);
    chk("lamp_nohex_seg", if_nohex.seg, 7'h7F);
    chk("lamp_nohex_inv", {6'd0, if_nohex.invalid}, 7'h00);
    step(4'd12, 1'b1, 1'b0);
    chk("blank_nohex_c_seg", if_nohex.seg, 7'h00);
    chk("blank_nohex_c_inv", {6'd0, if_nohex.invalid}, 7'h00);

    // Latency: toggle 1/7 every cycle; before each edge the old value must still show.
    step(4'd1, 1'b0, 1'b0);
    exp_prev = 7'h06;
    for (int k = 0; k < 8; k++) begin
      v       = (k % 2 == 0) ? 4'd7 : 4'd1;
      exp_now = (k % 2 == 0) ? 7'h07 : 7'h06;
      @(negedge clk);
      bcd = v;
      #1;
      chk($sformatf("lat_pre_%0d", k), if_hex.seg, exp_prev);
      @(posedge clk);
      #1;
      chk($sformatf("lat_post_%0d", k), if_hex.seg, exp_now);
      exp_prev = exp_now;
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    step(4'd12, 1'b0, 1'b0);
    chk("pre_arst_nohex_inv", {6'd0, if_nohex.invalid}, 7'h01);
    chk("pre_arst_hex_seg",   if_hex.seg, 7'h39);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hex_seg",   if_hex.seg, 7'h00);
    chk("arst_nohex_inv", {6'd0, if_nohex.invalid}, 7'h00);
    chk("arst_ca_seg",    if_ca.seg, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;

    // Common-anode decode after reset release.
    step(4'd0, 1'b0, 1'b0);
    chk("ca_0", if_ca.seg, 7'h40);
    step(4'd1, 1'b0, 1'b0);
    chk("ca_1", if_ca.seg, 7'h79);
    step(4'd1, 1'b1, 1'b0);
    chk("ca_blank", if_ca.seg, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segment_display.md
# segment_display

Registered 4-bit code to 7-segment decoder for driving a single seven-segment digit. Decodes BCD 0–9 and, optionally, hex A–F into segment enables, with blanking and lamp-test overrides. It sits between the numeric datapath and the display pins, giving a glitch-free registered output one clock after the input code.

## Interface
- `HEX_EN`, default 1: 1 = codes 10–15 display as A, b, C, d, E, F; 0 = codes 10–15 blank the digit and raise `invalid`.
- `COMMON_ANODE`, default 0: 0 = segment lit when its bit is 1; 1 = all segment bits inverted, so lit = 0.
- `clk`  input  1  Single system clock, rising edge.
- `rst_n`  input  1  Reset, asynchronous and active-low. Asserting it clears all registers immediately. Release is sampled on `clk`.
- `bcd`  input  4  Code to display, 0–15.
- `blank`  input  1  1 = all segments off.
- `lamp_test`  input  1  1 = all segments on. Overrides `blank` and `bcd`.
- `seg`  output  7  Segment drive, `seg[0]`=a, `seg[1]`=b, … `seg[6]`=g. Registered.
- `invalid`  output  1  1 when the registered code is 10–15 and `HEX_EN`=0. Registered.

## Operation
- Logical pattern `p[6:0]` uses lit = 1 and the `seg[0]`=a ordering.
- Values 0–9:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
- Values 10–15 with `HEX_EN`=1: A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- Values 10–15 with `HEX_EN`=0: `p`=0x00 and `invalid_next`=1. In every other case `invalid_next`=0.
- Override priority, highest first:
  - `lamp_test`=1 → `p`=0x7F, `invalid_next`=0.
  - `blank`=1 → `p`=0x00, `invalid_next`=0.
  - Otherwise the decode above applies.
- Polarity: `seg_next` = `p` when `COMMON_ANODE`=0; `seg_next` = ~`p` when `COMMON_ANODE`=1.
- On each rising edge of `clk` with `rst_n`=1: `seg` <= `seg_next`, `invalid` <= `invalid_next`.
- Behaviour is purely combinational decode followed by one register stage. There is no state machine and no handshake; every input value is legal.

## Timing
- Latency: exactly 1 clock. The input sampled at edge N appears on `seg`/`invalid` right after edge N.
- Throughput: a new code every cycle.
- Reset values:
  - `seg` = all segments off, i.e. 0x00 with `COMMON_ANODE`=0 and 0x7F with `COMMON_ANODE`=1.
  - `invalid` = 0.
- Reset takes effect asynchronously, with no clock needed, including mid-stream. The first decoded value appears on the first rising edge after `rst_n` goes high.
- If `lamp_test` and `blank` change in the same cycle as `bcd`, the priority rule applies to the values sampled at that edge.
- All inputs must be synchronous to `clk`. Outputs are glitch-free because they come straight from flops.

## Test plan
- Reset: hold `rst_n`=0 with `bcd`=8 and clock running → `seg`=0x00, `invalid`=0. Assert `rst_n` low mid-stream with no clock edge → outputs clear immediately.
- Full sweep, `HEX_EN`=1, `COMMON_ANODE`=0: `bcd`=0..15, one value per cycle → `seg` one cycle later follows 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71, with `invalid`=0 throughout.
- `HEX_EN`=0 sweep: `bcd`=9 → `seg`=0x6F, `invalid`=0; `bcd`=10..15 → `seg`=0x00, `invalid`=1; `bcd`=0 → `seg`=0x3F, `invalid` falls to 0.
- Overrides: `bcd`=3 with `blank`=1 → 0x00; add `lamp_test`=1 → 0x7F; `lamp_test`=1 with `bcd`=12 and `HEX_EN`=0 → `seg`=0x7F, `invalid`=0.
- `COMMON_ANODE`=1: reset → `seg`=0x7F; `bcd`=0 → 0x40; `bcd`=1 → 0x79; `blank`=1 → 0x7F.
- Latency check: toggle `bcd` between 1 and 7 every cycle → `seg` alternates 0x06/0x07, lagging the input by exactly one edge.
